// File: rtl/kogge_stone_adder_if.sv
// Operand/result bundle for the registered Kogge-Stone adder.
interface kogge_stone_adder_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cin;
  logic [N-1:0] sum;
  logic         cout;

  modport master (output A, output B, output cin, input sum, input cout);
  modport slave  (input A, input B, input cin, output sum, output cout);
endinterface

// File: rtl/kogge_stone_adder.sv
// N-bit adder on a Kogge-Stone parallel-prefix carry network; sum and carry-out
// are registered, cleared asynchronously by rst_n.
module kogge_stone_adder #(
  parameter int unsigned N = 8
) (
  input logic               clk,
  input logic               rst_n,
  kogge_stone_adder_if.slave bus
);
  localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 0;

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] g0;
  logic [N-1:0] gf;
  logic [N-1:0] c;
  logic [N-1:0] s;

  assign g = bus.A & bus.B;
  assign p = bus.A ^ bus.B;

  // cin is folded into bit 0 so every Gf[i] already includes it
  always_comb begin
    g0    = g;
    g0[0] = g[0] | (p[0] & bus.cin);
  end

  // Each level lives in its own generate scope so signals never depend on
  // other bits of themselves.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned D = 1 << k;
    logic [N-1:0] gi;
    logic [N-1:0] pi;
    logic [N-1:0] gn;
    logic [N-1:0] pn;

    if (k == 0) begin : g_first
      assign gi = g0;
      assign pi = p;
    end else begin : g_next
      assign gi = g_lvl[k-1].gn;
      assign pi = g_lvl[k-1].pn;
    end

    always_comb begin
      gn = gi;
      pn = pi;
      for (int unsigned i = D; i < N; i++) begin
        gn[i] = gi[i] | (pi[i] & gi[i-D]);
        pn[i] = pi[i] & pi[i-D];
      end
    end
  end

  if (LEVELS == 0) begin : g_no_prefix
    assign gf = g0;
  end else begin : g_prefix_out
    assign gf = g_lvl[LEVELS-1].gn;
  end

  always_comb begin
    c    = '0;
    c[0] = bus.cin;
    for (int unsigned i = 1; i < N; i++) begin
      c[i] = gf[i-1];
    end
  end

  assign s = p ^ c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.sum  <= s;
      bus.cout <= gf[N-1];
    end
  end
endmodule

// File: tb/tb_kogge_stone_adder.sv
// Self-checking bench: directed vector table, reset corners, exhaustive N=8 and
// random N=1/5/16/32 checked against plain integer addition.
module tb_kogge_stone_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  kogge_stone_adder_if #(.N(8))  bus8  ();
  kogge_stone_adder_if #(.N(8))  bus8b ();
  kogge_stone_adder_if #(.N(1))  bus1  ();
  kogge_stone_adder_if #(.N(5))  bus5  ();
  kogge_stone_adder_if #(.N(16)) bus16 ();
  kogge_stone_adder_if #(.N(32)) bus32 ();

  kogge_stone_adder #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  kogge_stone_adder #(.N(8))  dut8b (.clk(clk), .rst_n(rst_n), .bus(bus8b));
  kogge_stone_adder #(.N(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  kogge_stone_adder #(.N(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5));
  kogge_stone_adder #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  kogge_stone_adder #(.N(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[10];

  logic [63:0] exp1, exp5, exp16, exp32, exp8a, exp8b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
    return 64'(a) + 64'(b) + 64'(c);
  endfunction

  task automatic drive_rand();
    logic [31:0] ra, rb, rc;
    ra = $urandom; rb = $urandom; rc = $urandom;
    bus1.A  = ra[0];     bus1.B  = rb[0];     bus1.cin  = rc[0];
    ra = $urandom; rb = $urandom; rc = $urandom;
    bus5.A  = ra[4:0];   bus5.B  = rb[4:0];   bus5.cin  = rc[0];
    ra = $urandom; rb = $urandom; rc = $urandom;
    bus16.A = ra[15:0];  bus16.B = rb[15:0];  bus16.cin = rc[0];
    ra = $urandom; rb = $urandom; rc = $urandom;
    bus32.A = ra;        bus32.B = rb;        bus32.cin = rc[0];
    exp1  = model(32'(bus1.A),  32'(bus1.B),  bus1.cin);
    exp5  = model(32'(bus5.A),  32'(bus5.B),  bus5.cin);
    exp16 = model(32'(bus16.A), 32'(bus16.B), bus16.cin);
    exp32 = model(bus32.A,      bus32.B,      bus32.cin);
  endtask

  task automatic check_rand();
    check("rand_n1",  64'({bus1.cout,  bus1.sum}),  exp1);
    check("rand_n5",  64'({bus5.cout,  bus5.sum}),  exp5);
    check("rand_n16", 64'({bus16.cout, bus16.sum}), exp16);
    check("rand_n32", 64'({bus32.cout, bus32.sum}), exp32);
  endtask

  initial begin
    vecs[0] = '{8'hAA, 8'h66, 1'b0, 8'h10, 1'b1};
    vecs[1] = '{8'hCC, 8'h66, 1'b0, 8'h32, 1'b1};
    vecs[2] = '{8'hCC, 8'h3C, 1'b0, 8'h08, 1'b1};
    vecs[3] = '{8'hCC, 8'h3C, 1'b1, 8'h09, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    // Reset held with all-ones inputs
    rst_n = 1'b0;
    bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.cin = 1'b1;
    bus8b.A = '0;   bus8b.B = '0;   bus8b.cin = 1'b1;
    drive_rand();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", 64'({bus8.cout, bus8.sum}), 64'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", 64'({bus8.cout, bus8.sum}), 64'h1FF);

    // Directed table, back-to-back
    for (int i = 0; i <= 10; i++) begin
      if (i > 0)
        check($sformatf("vec%0d", i - 1), 64'({bus8.cout, bus8.sum}),
              64'({vecs[i-1].co, vecs[i-1].s}));
      if (i < 10) begin
        bus8.A = vecs[i].a; bus8.B = vecs[i].b; bus8.cin = vecs[i].cin;
      end
      @(negedge clk);
    end

    // Asynchronous reset between edges
    bus8.A = 8'h12; bus8.B = 8'h34; bus8.cin = 1'b1;
    @(posedge clk);
    #1;
    check("pre_async", 64'({bus8.cout, bus8.sum}), 64'h047);
    #1 rst_n = 1'b0;
    #1;
    check("async_clear", 64'({bus8.cout, bus8.sum}), 64'h0);
    bus8.A = 8'hF0; bus8.B = 8'h20; bus8.cin = 1'b0;
    @(posedge clk);
    #1;
    check("reset_ignores_inputs", 64'({bus8.cout, bus8.sum}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("no_stale_before_edge", 64'({bus8.cout, bus8.sum}), 64'h0);
    @(negedge clk);
    check("capture_after_release", 64'({bus8.cout, bus8.sum}), 64'h110);

    // Exhaustive N=8 (cin=0 on one instance, cin=1 on the other) plus random widths
    bus8.cin = 1'b0;
    bus8b.cin = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        bus8.A  = a[7:0]; bus8.B  = b[7:0];
        bus8b.A = a[7:0]; bus8b.B = b[7:0];
        exp8a = model(32'(a[7:0]), 32'(b[7:0]), 1'b0);
        exp8b = model(32'(a[7:0]), 32'(b[7:0]), 1'b1);
        drive_rand();
        @(negedge clk);
        check("exh_cin0", 64'({bus8.cout, bus8.sum}), exp8a);
        check("exh_cin1", 64'({bus8b.cout, bus8b.sum}), exp8b);
        check_rand();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
